// File: rtl/axis_log_packer_pkg.sv
// Shared definitions for the AXI-Stream log packer: FSM encoding, header
// field layout and the record marker.
package axis_log_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DAT  = 2'd2
  } state_t;

  localparam int HDR_TS_LSB   = 32;
  localparam int HDR_TS_W     = 32;
  localparam int HDR_SEQ_LSB  = 16;
  localparam int HDR_SEQ_W    = 16;
  localparam int HDR_KEEP_LSB = 8;
  localparam int HDR_KEEP_W   = 8;
  localparam int HDR_MARK_LSB = 3;
  localparam int HDR_MARK_W   = 5;
  localparam int HDR_LAST_BIT = 2;
  localparam int HDR_ID_BIT   = 1;
  localparam int HDR_DEST_BIT = 0;

  localparam logic [HDR_MARK_W-1:0] HDR_MARKER = 5'b10101;

  function automatic logic [63:0] make_header(
    input logic [HDR_TS_W-1:0]   ts,
    input logic [HDR_SEQ_W-1:0]  seq,
    input logic [HDR_KEEP_W-1:0] keep,
    input logic                  last,
    input logic                  id,
    input logic                  dest
  );
    logic [63:0] h;
    h = '0;
    h[HDR_TS_LSB   +: HDR_TS_W]   = ts;
    h[HDR_SEQ_LSB  +: HDR_SEQ_W]  = seq;
    h[HDR_KEEP_LSB +: HDR_KEEP_W] = keep;
    h[HDR_MARK_LSB +: HDR_MARK_W] = HDR_MARKER;
    h[HDR_LAST_BIT]               = last;
    h[HDR_ID_BIT]                 = id;
    h[HDR_DEST_BIT]               = dest;
    return h;
  endfunction

endpackage

// File: rtl/axis_log_packer_if.sv
// Bundles the logged input stream and the packed record output stream.
// A transfer occurs on a rising clk edge where TVALID and TREADY are both high;
// once TVALID rises it stays high with payload stable until that transfer.
interface axis_log_packer_if;
  logic [63:0] in_TDATA;
  logic        in_TVALID;
  logic        in_TREADY;
  logic [7:0]  in_TKEEP;
  logic        in_TDEST;
  logic        in_TID;
  logic        in_TLAST;

  logic [63:0] out_TDATA;
  logic        out_TVALID;
  logic        out_TREADY;
  logic [7:0]  out_TKEEP;
  logic        out_TLAST;

  modport slave (
    input  in_TDATA, in_TVALID, in_TKEEP, in_TDEST, in_TID, in_TLAST, out_TREADY,
    output in_TREADY, out_TDATA, out_TVALID, out_TKEEP, out_TLAST
  );

  modport master (
    output in_TDATA, in_TVALID, in_TKEEP, in_TDEST, in_TID, in_TLAST, out_TREADY,
    input  in_TREADY, out_TDATA, out_TVALID, out_TKEEP, out_TLAST
  );
endinterface

// File: rtl/axis_log_packer.sv
// Turns each logged input flit into a header flit (timestamp, sequence, side
// channels) followed by the unchanged data flit. All outputs come from flops.
module axis_log_packer
  import axis_log_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  axis_log_packer_if.slave   bus,
  output state_t             o_state
);

  if (DATA_WIDTH != 64) begin : g_width_check
    $error("axis_log_packer: DATA_WIDTH must be 64");
  end

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_hdr_done;
  logic        w_dat_done;

  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_out_last;
  logic [63:0] r_out_data;
  logic [63:0] r_data_hold;
  logic        r_last_hold;
  logic [15:0] r_seq;
  logic [31:0] r_ts;

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_hdr_done = 1'b0;
    w_dat_done = 1'b0;
    case (r_state)
      // r_in_ready is low for the first IDLE cycle after reset, so gate on it
      ST_IDLE: if (bus.in_TVALID && r_in_ready) begin
        w_accept = 1'b1;
        w_next   = ST_HDR;
      end
      ST_HDR: if (bus.out_TREADY) begin
        w_hdr_done = 1'b1;
        w_next     = ST_DAT;
      end
      ST_DAT: if (bus.out_TREADY) begin
        w_dat_done = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 32'd1;
  end

  // Output slice doubles as capture storage: header goes out directly, data waits in r_data_hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_data_hold <= '0;
      r_last_hold <= 1'b0;
      r_seq       <= '0;
    end else begin
      r_in_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b0;
        r_out_data  <= make_header(r_ts, r_seq, bus.in_TKEEP, bus.in_TLAST,
                                   bus.in_TID, bus.in_TDEST);
        r_data_hold <= bus.in_TDATA;
        r_last_hold <= bus.in_TLAST;
      end else if (w_hdr_done) begin
        r_out_data <= r_data_hold;
        r_out_last <= r_last_hold;
      end else if (w_dat_done) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_seq       <= r_seq + 16'd1;
      end
    end
  end

  assign bus.in_TREADY  = r_in_ready;
  assign bus.out_TVALID = r_out_valid;
  assign bus.out_TDATA  = r_out_data;
  assign bus.out_TLAST  = r_out_last;
  assign bus.out_TKEEP  = 8'hFF;
  assign o_state        = r_state;

endmodule

// File: tb/tb_axis_log_packer.sv
// Bench for axis_log_packer: directed record scenarios plus a long random
// handshake run, all checked against a queue-based record model.
module tb_axis_log_packer;
  import axis_log_pkg::*;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  axis_log_packer_if bus();
  state_t dbg_state;

  axis_log_packer #(.DATA_WIDTH(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: each entry {is_data, last, flit}
  logic [65:0] exp_q[$];
  logic [63:0] hdr_log[$];
  logic [63:0] dat_log[$];
  logic        dat_last_log[$];
  int          hdr_cyc[$];
  int          dat_cyc[$];
  int          acc_cyc[$];
  logic [31:0] ts_now;
  logic [15:0] seq_m;
  logic        rst_prev;
  logic        prev_stall;
  logic [63:0] prev_data;
  int          cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Model: in_TREADY high exactly when no record is pending, out_TVALID when one is.
  always @(negedge clk) begin
    logic [65:0] e;
    cyc++;
    if (rst) begin
      ts_now     = '0;
      seq_m      = '0;
      rst_prev   = 1'b1;
      prev_stall = 1'b0;
      exp_q.delete();
      check("rst_out_valid", bus.out_TVALID, 0);
      check("rst_in_ready", bus.in_TREADY, 0);
      check("rst_out_data", bus.out_TDATA, 0);
      check("rst_out_last", bus.out_TLAST, 0);
    end else begin
      ts_now = rst_prev ? 32'd0 : ts_now + 32'd1;
      check("in_ready", bus.in_TREADY, (!rst_prev && exp_q.size() == 0));
      check("out_valid", bus.out_TVALID, (exp_q.size() != 0));
      if (prev_stall) check("out_stable", bus.out_TDATA, prev_data);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("out_data", bus.out_TDATA, e[63:0]);
        check("out_last", bus.out_TLAST, e[64]);
        check("out_keep", bus.out_TKEEP, 8'hFF);
      end
      prev_stall = bus.out_TVALID && !bus.out_TREADY;
      prev_data  = bus.out_TDATA;
      if (bus.out_TVALID && bus.out_TREADY && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e[65]) begin
          seq_m = seq_m + 16'd1;
          dat_log.push_back(bus.out_TDATA);
          dat_last_log.push_back(bus.out_TLAST);
          dat_cyc.push_back(cyc);
        end else begin
          hdr_log.push_back(bus.out_TDATA);
          hdr_cyc.push_back(cyc);
        end
      end
      if (bus.in_TVALID && bus.in_TREADY) begin
        exp_q.push_back({1'b0, 1'b0, ts_now, seq_m, bus.in_TKEEP, 5'b10101,
                         bus.in_TLAST, bus.in_TID, bus.in_TDEST});
        exp_q.push_back({1'b1, bus.in_TLAST, bus.in_TDATA});
        acc_cyc.push_back(cyc);
      end
      rst_prev = 1'b0;
    end
  end

  // driver tasks
  task automatic clear_logs();
    hdr_log.delete();
    dat_log.delete();
    dat_last_log.delete();
    hdr_cyc.delete();
    dat_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_TVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    clear_logs();
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_rise", bus.in_TREADY, 1);
  endtask

  task automatic send_flit(input logic [63:0] d, input logic [7:0] k,
                           input logic dest, input logic id, input logic last);
    logic acc;
    bus.in_TDATA  = d;
    bus.in_TKEEP  = k;
    bus.in_TDEST  = dest;
    bus.in_TID    = id;
    bus.in_TLAST  = last;
    bus.in_TVALID = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_TREADY;
      @(posedge clk); #1;
    end
    if (!acc) timeout_fail("send_flit");
    bus.in_TVALID = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) timeout_fail(name);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] held;
    logic        acc;
    int          n_acc;
    rst = 1'b1;
    bus.in_TDATA   = '0;
    bus.in_TKEEP   = '0;
    bus.in_TDEST   = 1'b0;
    bus.in_TID     = 1'b0;
    bus.in_TLAST   = 1'b0;
    bus.in_TVALID  = 1'b0;
    bus.out_TREADY = 1'b1;

    // single flit, pinned by hand-computed values
    do_reset();
    send_flit(64'h1122334455667788, 8'h0F, 1'b1, 1'b0, 1'b1);
    wait_drain("t1_drain");
    check("t1_hdr_cnt", hdr_log.size(), 1);
    check("t1_dat_cnt", dat_log.size(), 1);
    if (hdr_log.size() == 1 && dat_log.size() == 1) begin
      check("t1_hdr_low", hdr_log[0][31:0], 32'h00000FAD);
      check("t1_data", dat_log[0], 64'h1122334455667788);
      check("t1_data_last", dat_last_log[0], 1);
      check("t1_consec", dat_cyc[0] - hdr_cyc[0], 1);
      check("t1_hdr_lat", hdr_cyc[0] - acc_cyc[0], 1);
    end

    // back-to-back
    do_reset();
    for (int i = 0; i < 4; i++)
      send_flit({$urandom(), $urandom()}, 8'($urandom()), 1'b0, 1'b1, 1'($urandom()));
    wait_drain("t2_drain");
    check("t2_hdr_cnt", hdr_log.size(), 4);
    if (hdr_log.size() == 4 && acc_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t2_seq", hdr_log[i][31:16], i);
      for (int i = 1; i < 4; i++) begin
        check("t2_ts_gap", hdr_log[i][63:32] - hdr_log[i-1][63:32], 3);
        check("t2_acc_gap", acc_cyc[i] - acc_cyc[i-1], 3);
      end
    end

    // backpressure during HDR
    do_reset();
    bus.out_TREADY = 1'b0;
    send_flit(64'hA5A5_0000_FFFF_1234, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    held = bus.out_TDATA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_state_hdr", dbg_state, ST_HDR);
      check("t3_ready_low", bus.in_TREADY, 0);
      check("t3_hdr_held", bus.out_TDATA, held);
    end
    @(posedge clk); #1;
    bus.out_TREADY = 1'b1;
    wait_drain("t3_drain");
    check("t3_hdr_cnt", hdr_log.size(), 1);
    check("t3_dat_cnt", dat_log.size(), 1);
    if (hdr_log.size() == 1) check("t3_seq", hdr_log[0][31:16], 0);
    send_flit(64'h5, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_drain("t3_drain2");
    if (hdr_log.size() == 2) check("t3_seq_next", hdr_log[1][31:16], 1);
    else timeout_fail("t3_hdr_cnt2");

    // sequence wrap
    do_reset();
    force dut.r_seq = 16'hFFFF;
    seq_m = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_seq;
    send_flit(64'h1, 8'h03, 1'b1, 1'b1, 1'b0);
    send_flit(64'h2, 8'h07, 1'b0, 1'b1, 1'b1);
    wait_drain("t4_drain");
    check("t4_hdr_cnt", hdr_log.size(), 2);
    if (hdr_log.size() == 2) begin
      check("t4_seq_ffff", hdr_log[0][31:16], 16'hFFFF);
      check("t4_seq_wrap", hdr_log[1][31:16], 16'h0000);
    end

    // reset while in DAT
    do_reset();
    bus.out_TREADY = 1'b0;
    send_flit(64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b1, 1'b0, 1'b1);
    bus.out_TREADY = 1'b1;
    @(posedge clk); #1;
    bus.out_TREADY = 1'b0;
    check("t5_state_dat", dbg_state, ST_DAT);
    rst = 1'b1;
    #1;
    check("t5_async_valid", bus.out_TVALID, 0);
    check("t5_async_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst = 1'b0;
    @(posedge clk); #1;
    bus.out_TREADY = 1'b1;
    send_flit(64'h0123_4567_89AB_CDEF, 8'h3C, 1'b0, 1'b1, 1'b0);
    wait_drain("t5_drain");
    check("t5_dat_cnt", dat_log.size(), 1);
    if (dat_log.size() == 1 && hdr_log.size() == 1) begin
      check("t5_new_data", dat_log[0], 64'h0123_4567_89AB_CDEF);
      check("t5_seq0", hdr_log[0][31:16], 0);
    end

    // random handshakes
    do_reset();
    acc   = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!bus.in_TVALID || acc) begin
        bus.in_TVALID = ($urandom_range(0, 99) < 60);
        bus.in_TDATA  = {$urandom(), $urandom()};
        bus.in_TKEEP  = 8'($urandom());
        bus.in_TDEST  = 1'($urandom());
        bus.in_TID    = 1'($urandom());
        bus.in_TLAST  = 1'($urandom());
      end
      bus.out_TREADY = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_TVALID && bus.in_TREADY;
      if (acc) n_acc++;
      @(posedge clk); #1;
    end
    bus.in_TVALID  = 1'b0;
    bus.out_TREADY = 1'b1;
    wait_drain("t6_drain");
    check("t6_records", dat_log.size(), n_acc);
    check("t6_headers", hdr_log.size(), n_acc);

    // report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
